// File: rtl/hp_region_sched_pkg.sv
// Shared types and parameter defaults for the region-rotating CNN inference scheduler.
package hp_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_INFER  = 2'd2,
        ST_COMMIT = 2'd3
    } sched_state_e;

    localparam int THRESH_DEF      = 0;
    localparam int TIMEOUT_CYC_DEF = 1 << 20;
    localparam int SET_CNT_DEF     = 2;
    localparam int CLR_CNT_DEF     = 4;
    localparam int HIST_W          = 8;

endpackage

// File: rtl/hp_region_sched_if.sv
// Handshake and result bundle between the scheduler (slave) and its environment (master).
interface hp_region_sched_if #(
    parameter int NUM_REGIONS = 6,
    parameter int SCORE_W     = 16
);
    localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    logic                      i_ml_rdy;
    logic                      i_hold;
    logic                      o_rd_rdy;
    logic                      i_rd_done;
    logic [SEL_W-1:0]          o_frame_sel;
    logic                      i_score_vld;
    logic signed [SCORE_W-1:0] i_score;
    logic [NUM_REGIONS-1:0]    o_det_vec;
    logic                      o_det_any;
    logic                      o_det_filt;
    logic                      o_busy;
    logic                      o_timeout;

    modport slave (
        input  i_ml_rdy, i_hold, i_rd_done, i_score_vld, i_score,
        output o_rd_rdy, o_frame_sel, o_det_vec, o_det_any, o_det_filt, o_busy, o_timeout
    );

    modport master (
        output i_ml_rdy, i_hold, i_rd_done, i_score_vld, i_score,
        input  o_rd_rdy, o_frame_sel, o_det_vec, o_det_any, o_det_filt, o_busy, o_timeout
    );

endinterface

// File: rtl/hp_region_sched_det_filter.sv
// Decision history shift register with set/clear hysteresis on the most recent bits.
module hp_det_filter
    import hp_sched_pkg::*;
#(
    parameter int SET_CNT = SET_CNT_DEF,
    parameter int CLR_CNT = CLR_CNT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic shift_en,
    input  logic dec,
    output logic filt
);
    localparam logic [HIST_W-1:0] SET_MASK = HIST_W'((1 << SET_CNT) - 1);
    localparam logic [HIST_W-1:0] CLR_MASK = HIST_W'((1 << CLR_CNT) - 1);

    logic [HIST_W-1:0] hist_q, hist_d;
    logic              filt_q, filt_d;

    always_comb begin
        hist_d = hist_q;
        filt_d = filt_q;
        if (shift_en) hist_d = {hist_q[HIST_W-2:0], dec};
        // SET_CNT <= CLR_CNT, so set and clear can never both be true
        if ((hist_q & SET_MASK) == SET_MASK)  filt_d = 1'b1;
        else if ((hist_q & CLR_MASK) == '0)   filt_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/hp_region_sched.sv
// Rotates CNN inference over NUM_REGIONS frame selections and records a per-region detection.
module hp_region_sched
    import hp_sched_pkg::*;
#(
    parameter int NUM_REGIONS = 6,
    parameter int SCORE_W     = 16,
    parameter int THRESH      = THRESH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int SET_CNT     = SET_CNT_DEF,
    parameter int CLR_CNT     = CLR_CNT_DEF
) (
    input  logic clk,
    input  logic reset,
    hp_region_sched_if.slave bus
);
    localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int CMP_W = (SCORE_W > 32) ? SCORE_W : 32;
    localparam logic [SEL_W-1:0]        SEL_LAST = SEL_W'(NUM_REGIONS - 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic signed [CMP_W-1:0] THRESH_X = CMP_W'(THRESH);

    sched_state_e              state_q, state_d;
    logic                      rd_rdy_q, rd_rdy_d;
    logic                      busy_q, busy_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [NUM_REGIONS-1:0]    det_vec_q, det_vec_d;
    logic                      det_any_q, det_any_d;
    logic                      timeout_q, timeout_d;
    logic                      to_hit_q, to_hit_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [SCORE_W-1:0] score_q, score_d;
    logic                      rd_done_dly_q;
    logic                      rd_edge, shift_en, dec;
    logic signed [CMP_W-1:0]   score_x;

    assign rd_edge = bus.i_rd_done & ~rd_done_dly_q;
    assign score_x = CMP_W'(score_q);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        det_vec_d = det_vec_q;
        timeout_d = timeout_q;
        to_hit_d  = to_hit_q;
        cnt_d     = cnt_q;
        score_d   = score_q;
        shift_en  = 1'b0;
        dec       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_ml_rdy && !bus.i_hold) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (rd_edge) begin
                    state_d  = ST_INFER;
                    cnt_d    = '0;
                    to_hit_d = 1'b0;
                end else if (!bus.i_ml_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_INFER: begin
                // a score arriving on the last allowed cycle still counts
                if (bus.i_score_vld) begin
                    score_d  = bus.i_score;
                    to_hit_d = 1'b0;
                    state_d  = ST_COMMIT;
                end else if (cnt_q == CNT_LAST) begin
                    to_hit_d  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                dec              = !to_hit_q && (score_x >= THRESH_X);
                det_vec_d[sel_q] = dec;
                shift_en         = 1'b1;
                sel_d            = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // grant goes high one cycle into GRANT and drops on the edge that leaves it
        rd_rdy_d  = (state_q == ST_GRANT) && (state_d == ST_GRANT);
        busy_d    = (state_d != ST_IDLE);
        det_any_d = |det_vec_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rd_rdy_q      <= 1'b0;
            busy_q        <= 1'b0;
            sel_q         <= '0;
            det_vec_q     <= '0;
            det_any_q     <= 1'b0;
            timeout_q     <= 1'b0;
            to_hit_q      <= 1'b0;
            cnt_q         <= '0;
            score_q       <= '0;
            rd_done_dly_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            rd_rdy_q      <= rd_rdy_d;
            busy_q        <= busy_d;
            sel_q         <= sel_d;
            det_vec_q     <= det_vec_d;
            det_any_q     <= det_any_d;
            timeout_q     <= timeout_d;
            to_hit_q      <= to_hit_d;
            cnt_q         <= cnt_d;
            score_q       <= score_d;
            rd_done_dly_q <= bus.i_rd_done;
        end
    end

    hp_det_filter #(
        .SET_CNT (SET_CNT),
        .CLR_CNT (CLR_CNT)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .dec      (dec),
        .filt     (bus.o_det_filt)
    );

    assign bus.o_rd_rdy    = rd_rdy_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_frame_sel = sel_q;
    assign bus.o_det_vec   = det_vec_q;
    assign bus.o_det_any   = det_any_q;
    assign bus.o_timeout   = timeout_q;

endmodule

// File: tb/tb_hp_region_sched.sv
// Directed bench for hp_region_sched: latency, rotation, hysteresis, timeout, hold and reset.
module tb_hp_region_sched;
    import hp_sched_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic ml_rdy, hold, rd_done, score_vld;
    logic [15:0] score;
    int n_pass = 0;
    int n_chk  = 0;

    hp_region_sched_if #(.NUM_REGIONS(6), .SCORE_W(16)) bus ();

    assign bus.i_ml_rdy    = ml_rdy;
    assign bus.i_hold      = hold;
    assign bus.i_rd_done   = rd_done;
    assign bus.i_score_vld = score_vld;
    assign bus.i_score     = score;

    hp_region_sched #(
        .NUM_REGIONS (6),
        .SCORE_W     (16),
        .THRESH      (0),
        .TIMEOUT_CYC (16),
        .SET_CNT     (2),
        .CLR_CNT     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; ml_rdy = 1'b0; hold = 1'b0;
        rd_done = 1'b0; score_vld = 1'b0; score = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!bus.o_rd_rdy && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.o_rd_rdy), 32'd1);
    endtask

    // Returns two edges after the commit, when det_any and det_filt have settled.
    task automatic frame(input logic [15:0] s);
        wait_rdy("frame_rdy");
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0; score_vld = 1'b1; score = s;
        tick();
        score_vld = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1; ml_rdy = 1'b0; hold = 1'b0;
        rd_done = 1'b0; score_vld = 1'b0; score = '0;
        repeat (2) tick();
        chk("rst_rd_rdy",  32'(bus.o_rd_rdy),    32'd0);
        chk("rst_sel",     32'(bus.o_frame_sel), 32'd0);
        chk("rst_vec",     32'(bus.o_det_vec),   32'd0);
        chk("rst_any",     32'(bus.o_det_any),   32'd0);
        chk("rst_filt",    32'(bus.o_det_filt),  32'd0);
        chk("rst_busy",    32'(bus.o_busy),      32'd0);
        chk("rst_timeout", 32'(bus.o_timeout),   32'd0);

        // single frame, latency from score pulse
        reset = 1'b0; ml_rdy = 1'b1;
        tick();
        chk("s1_busy_grant", 32'(bus.o_busy),   32'd1);
        chk("s1_rdy_lag",    32'(bus.o_rd_rdy), 32'd0);
        tick();
        chk("s1_rdy", 32'(bus.o_rd_rdy), 32'd1);
        score_vld = 1'b1; score = 16'h0100;
        tick();
        score_vld = 1'b0;
        chk("s1_vld_in_grant_rdy", 32'(bus.o_rd_rdy),  32'd1);
        chk("s1_vld_in_grant_vec", 32'(bus.o_det_vec), 32'd0);
        rd_done = 1'b1;
        tick();
        chk("s1_infer_rdy_low", 32'(bus.o_rd_rdy), 32'd0);
        rd_done = 1'b0; score_vld = 1'b1; score = 16'h0100;
        tick();
        score_vld = 1'b0;
        chk("s1_vec_at_E", 32'(bus.o_det_vec), 32'd0);
        tick();
        chk("s1_vec_E1", 32'(bus.o_det_vec),   32'd1);
        chk("s1_sel_E1", 32'(bus.o_frame_sel), 32'd1);
        chk("s1_any_E1", 32'(bus.o_det_any),   32'd0);
        tick();
        chk("s1_any_E2",  32'(bus.o_det_any),  32'd1);
        chk("s1_rdy_E2",  32'(bus.o_rd_rdy),   32'd0);
        chk("s1_filt_E2", 32'(bus.o_det_filt), 32'd0);
        tick();
        chk("s1_rdy_E3", 32'(bus.o_rd_rdy), 32'd1);
        ml_rdy = 1'b0;
        tick();
        chk("grant_abort_rdy",  32'(bus.o_rd_rdy), 32'd0);
        chk("grant_abort_busy", 32'(bus.o_busy),   32'd0);

        // six alternating scores rotate through every region
        do_reset();
        ml_rdy = 1'b1;
        for (int i = 0; i < 6; i++) frame((i % 2 == 0) ? 16'h0005 : 16'hFFFB);
        chk("s2_vec",  32'(bus.o_det_vec),   32'h15);
        chk("s2_sel",  32'(bus.o_frame_sel), 32'd0);
        chk("s2_any",  32'(bus.o_det_any),   32'd1);
        chk("s2_filt", 32'(bus.o_det_filt),  32'd0);

        // hysteresis and signed threshold boundaries
        do_reset();
        ml_rdy = 1'b1;
        frame(16'h7FFF);
        chk("s3_filt_1", 32'(bus.o_det_filt), 32'd0);
        frame(16'h0000);
        chk("s3_filt_11", 32'(bus.o_det_filt), 32'd1);
        frame(16'hFFFF);
        chk("s3_filt_110", 32'(bus.o_det_filt), 32'd1);
        frame(16'h8000);
        chk("s3_vec_signed", 32'(bus.o_det_vec),  32'h03);
        chk("s3_filt_1100",  32'(bus.o_det_filt), 32'd1);
        frame(16'hFFFB);
        chk("s3_filt_11000", 32'(bus.o_det_filt), 32'd1);
        frame(16'hFF9C);
        chk("s3_filt_cleared", 32'(bus.o_det_filt),  32'd0);
        chk("s3_sel_wrap",     32'(bus.o_frame_sel), 32'd0);

        // score on the last INFER cycle wins, then a real timeout
        do_reset();
        ml_rdy = 1'b1;
        wait_rdy("s4a_rdy");
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        repeat (15) tick();
        chk("s4a_busy_infer", 32'(bus.o_busy), 32'd1);
        score_vld = 1'b1; score = 16'h0005;
        tick();
        score_vld = 1'b0;
        chk("s4a_race_no_timeout", 32'(bus.o_timeout), 32'd0);
        tick();
        chk("s4a_race_vec", 32'(bus.o_det_vec),   32'h01);
        chk("s4a_race_sel", 32'(bus.o_frame_sel), 32'd1);
        wait_rdy("s4b_rdy");
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        repeat (15) tick();
        chk("s4b_timeout_early", 32'(bus.o_timeout), 32'd0);
        tick();
        chk("s4b_timeout_set", 32'(bus.o_timeout),   32'd1);
        chk("s4b_sel_pre",     32'(bus.o_frame_sel), 32'd1);
        tick();
        chk("s4b_vec", 32'(bus.o_det_vec),   32'h01);
        chk("s4b_sel", 32'(bus.o_frame_sel), 32'd2);
        score_vld = 1'b1; score = 16'h0005;
        tick();
        score_vld = 1'b0;
        chk("s4b_timeout_sticky", 32'(bus.o_timeout), 32'd1);

        // hold raised mid-INFER only blocks the next grant
        do_reset();
        ml_rdy = 1'b1;
        wait_rdy("s5_rdy");
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0; hold = 1'b1;
        repeat (2) tick();
        score_vld = 1'b1; score = 16'h0005;
        tick();
        score_vld = 1'b0;
        tick();
        chk("s5_vec", 32'(bus.o_det_vec),   32'h01);
        chk("s5_sel", 32'(bus.o_frame_sel), 32'd1);
        repeat (4) tick();
        chk("s5_held_busy", 32'(bus.o_busy),   32'd0);
        chk("s5_held_rdy",  32'(bus.o_rd_rdy), 32'd0);
        hold = 1'b0;
        tick();
        chk("s5_release_busy", 32'(bus.o_busy), 32'd1);
        tick();
        chk("s5_release_rdy", 32'(bus.o_rd_rdy), 32'd1);

        // reset mid-INFER discards the pending region
        do_reset();
        ml_rdy = 1'b1;
        frame(16'h0005);
        chk("s6_pre_vec", 32'(bus.o_det_vec), 32'h01);
        wait_rdy("s6_rdy");
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("s6_async_vec",  32'(bus.o_det_vec),   32'd0);
        chk("s6_async_sel",  32'(bus.o_frame_sel), 32'd0);
        chk("s6_async_any",  32'(bus.o_det_any),   32'd0);
        chk("s6_async_busy", 32'(bus.o_busy),      32'd0);
        chk("s6_async_rdy",  32'(bus.o_rd_rdy),    32'd0);
        tick();
        reset = 1'b0; ml_rdy = 1'b0; score_vld = 1'b1; score = 16'h0005;
        tick();
        score_vld = 1'b0;
        repeat (2) tick();
        chk("s6_post_vec",  32'(bus.o_det_vec),   32'd0);
        chk("s6_post_sel",  32'(bus.o_frame_sel), 32'd0);
        chk("s6_post_busy", 32'(bus.o_busy),      32'd0);

        // a done level already high when the grant arrives is not an edge
        rd_done = 1'b1; ml_rdy = 1'b1;
        repeat (2) tick();
        chk("s6_level_rdy", 32'(bus.o_rd_rdy), 32'd1);
        repeat (3) tick();
        chk("s6_level_still_grant", 32'(bus.o_rd_rdy), 32'd1);
        rd_done = 1'b0;
        tick();
        rd_done = 1'b1;
        tick();
        chk("s6_new_edge_infer", 32'(bus.o_rd_rdy), 32'd0);
        chk("s6_new_edge_busy",  32'(bus.o_busy),   32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hp_region_sched.md
HP_REGION_SCHED -- requirements
Module: hp_region_sched

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 6: number of frame/region selections rotated per cycle of inference.
REQ-002 SHALL have parameter SCORE_W, default 16: width of the signed class score.
REQ-003 SHALL have parameter THRESH, default 0: signed detection threshold; a region detects when score >= THRESH.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 2^20: maximum number of INFER cycles before the region is abandoned.
REQ-005 SHALL have parameters SET_CNT, default 2, and CLR_CNT, default 4: filter hysteresis depths, with 1 <= SET_CNT <= CLR_CNT <= 8.
REQ-006 SHALL have port clk  in  1  core clock; the block uses one clock.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port i_ml_rdy  in  1  CNN engine ready to accept a frame.
REQ-009 SHALL have port i_hold  in  1  debug hold; while high, no new grant is issued.
REQ-010 SHALL have port o_rd_rdy  out  1  grant to the video process to stream a frame.
REQ-011 SHALL have port i_rd_done  in  1  video transfer done level; its rising edge starts inference.
REQ-012 SHALL have port o_frame_sel  out  $clog2(NUM_REGIONS)  region currently scheduled.
REQ-013 SHALL have port i_score_vld  in  1  single-cycle pulse marking i_score valid.
REQ-014 SHALL have port i_score  in  SCORE_W  signed maximum class score from post-processing.
REQ-015 SHALL have port o_det_vec  out  NUM_REGIONS  per-region detection flags.
REQ-016 SHALL have port o_det_any  out  1  OR of o_det_vec, registered.
REQ-017 SHALL have port o_det_filt  out  1  hysteresis-filtered detection.
REQ-018 SHALL have port o_busy  out  1  high whenever the FSM state is not IDLE.
REQ-019 SHALL have port o_timeout  out  1  sticky flag, set by any INFER timeout.

Function
REQ-020 SHALL implement the FSM states IDLE, GRANT, INFER and COMMIT, encoded in a registered state register.
REQ-021 In IDLE, SHALL go to GRANT at the next edge when i_ml_rdy=1 and i_hold=0; otherwise it SHALL stay in IDLE.
REQ-022 SHALL drive o_rd_rdy high exactly while in GRANT, from a registered output.
REQ-023 In GRANT, SHALL go to INFER on a rising edge of i_rd_done, detected against a one-cycle delayed copy.
REQ-024 In GRANT, if i_ml_rdy falls before that edge, SHALL return to IDLE.
REQ-025 On entering INFER, SHALL clear the timeout counter.
REQ-026 In INFER, on i_score_vld=1, SHALL capture i_score and go to COMMIT.
REQ-027 In INFER, when the counter reaches TIMEOUT_CYC-1 with no i_score_vld, SHALL set o_timeout, force the region decision to 0 and go to COMMIT.
REQ-028 If i_score_vld and the timeout fall in the same cycle, the score SHALL win.
REQ-029 SHALL ignore i_score_vld in any state other than INFER, and SHALL ignore i_rd_done edges outside GRANT.
REQ-030 In COMMIT (one cycle), SHALL write the decision to o_det_vec[o_frame_sel].
REQ-031 In COMMIT, SHALL shift the decision into the 8-bit history register.
REQ-032 In COMMIT, SHALL advance o_frame_sel, wrapping from NUM_REGIONS-1 to 0, and then go to IDLE.
REQ-033 Latency: for i_score_vld sampled at edge E, o_det_vec, o_frame_sel and the history SHALL update at E+1, o_det_any/o_det_filt at E+2, and o_rd_rdy SHALL be high no earlier than E+3.
REQ-034 SHALL set o_det_filt when the last SET_CNT history bits are all 1, and clear it when the last CLR_CNT bits are all 0; otherwise o_det_filt SHALL hold.
REQ-035 Comparison against THRESH SHALL be signed, full SCORE_W width, with no truncation.
REQ-036 i_hold rising mid-operation SHALL NOT abort GRANT, INFER or COMMIT; it blocks only the IDLE-to-GRANT transition.

Reset
REQ-037 On reset=1, SHALL asynchronously set state=IDLE, o_rd_rdy=0, o_frame_sel=0, o_det_vec=0, o_det_any=0, o_det_filt=0, history=0, o_timeout=0, o_busy=0 and the timeout counter=0.
REQ-038 Reset asserted mid-INFER SHALL discard the pending result; no COMMIT occurs.
REQ-039 The i_rd_done delay register SHALL reset to 1 so that a level already high at release is not taken as an edge.

Structure
REQ-040 Package hp_sched_pkg SHALL hold the FSM state enum and the default values of THRESH, TIMEOUT_CYC, SET_CNT and CLR_CNT.
REQ-041 The history register and hysteresis logic SHALL be one sub-module, hp_det_filter (inputs: shift enable and decision bit; output: filt).

Verification
REQ-042 Scenario: i_ml_rdy=1, rd_done pulse, score 0x0100 -> o_det_vec[0]=1, o_frame_sel=1, o_rd_rdy re-asserts at E+3.
REQ-043 Scenario: six scores alternating +5/-5 -> o_det_vec=6'b010101, o_frame_sel wraps to 0, o_det_any=1.
REQ-044 Scenario: decisions 1,1 -> o_det_filt=1 after the second commit; then 0,0,0 -> still 1; a fourth 0 -> o_det_filt=0.
REQ-045 Scenario: TIMEOUT_CYC=16 with no score -> o_timeout=1 after 16 INFER cycles, the region bit is 0, o_frame_sel advances; also score and timeout in the same cycle -> the score is committed.
REQ-046 Scenario: i_hold=1 during INFER -> the commit completes and the FSM stays in IDLE until i_hold=0.
REQ-047 Scenario: reset pulse mid-INFER -> all outputs 0, and a later score pulse is ignored.
